// File: rtl/mlp_layer_sequencer_if.sv
// rtl/mlp_layer_sequencer_if.sv - run control and sub-unit handshake bundle for the MLP layer sequencer
interface mlp_layer_sequencer_if #(
  parameter int IDX_BITS = 1
);
  logic                start;
  logic                busy;
  logic                done;
  logic                error;
  logic                error_stage;
  logic [IDX_BITS-1:0] layer_idx;
  logic                dense_start;
  logic                dense_done;
  logic                relu_start;
  logic                relu_done;

  modport master (
    input  start,
    input  dense_done,
    input  relu_done,
    output busy,
    output done,
    output error,
    output error_stage,
    output layer_idx,
    output dense_start,
    output relu_start
  );

  modport slave (
    output start,
    output dense_done,
    output relu_done,
    input  busy,
    input  done,
    input  error,
    input  error_stage,
    input  layer_idx,
    input  dense_start,
    input  relu_start
  );
endinterface

// File: rtl/mlp_layer_sequencer.sv
// rtl/mlp_layer_sequencer.sv - steps dense and relu units through NUM_LAYERS layers per inference
// Moore FSM with a per-wait timeout; the output layer skips relu.
module mlp_layer_sequencer #(
  parameter int NUM_LAYERS     = 2,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int IDX_BITS       = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input logic                   clk,
  input logic                   reset,
  mlp_layer_sequencer_if.master bus
);

  localparam logic [2:0] ST_IDLE        = 3'd0;
  localparam logic [2:0] ST_DENSE_START = 3'd1;
  localparam logic [2:0] ST_DENSE_WAIT  = 3'd2;
  localparam logic [2:0] ST_RELU_START  = 3'd3;
  localparam logic [2:0] ST_RELU_WAIT   = 3'd4;
  localparam logic [2:0] ST_DONE        = 3'd5;
  localparam logic [2:0] ST_ERROR       = 3'd6;

  localparam int                  CNT_BITS   = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_BITS-1:0] CNT_LAST   = CNT_BITS'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_BITS-1:0] LAST_LAYER = IDX_BITS'(NUM_LAYERS - 1);

  logic [2:0]          state;
  logic [IDX_BITS-1:0] layer_q;
  logic [CNT_BITS-1:0] wait_cnt;
  logic                error_q;
  logic                error_stage_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      layer_q       <= '0;
      wait_cnt      <= '0;
      error_q       <= 1'b0;
      error_stage_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state   <= ST_DENSE_START;
            layer_q <= '0;
          end
        end
        ST_DENSE_START: begin
          state    <= ST_DENSE_WAIT;
          wait_cnt <= '0;
        end
        ST_DENSE_WAIT: begin
          // a done arriving on the last counted cycle still wins over the timeout
          if (bus.dense_done) begin
            state <= (layer_q != LAST_LAYER) ? ST_RELU_START : ST_DONE;
          end else if (wait_cnt == CNT_LAST) begin
            state         <= ST_ERROR;
            error_q       <= 1'b1;
            error_stage_q <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_RELU_START: begin
          state    <= ST_RELU_WAIT;
          wait_cnt <= '0;
        end
        ST_RELU_WAIT: begin
          if (bus.relu_done) begin
            state   <= ST_DENSE_START;
            layer_q <= layer_q + 1'b1;
          end else if (wait_cnt == CNT_LAST) begin
            state         <= ST_ERROR;
            error_q       <= 1'b1;
            error_stage_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        ST_ERROR: begin
          if (bus.start) begin
            state         <= ST_DENSE_START;
            layer_q       <= '0;
            error_q       <= 1'b0;
            error_stage_q <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = (state != ST_IDLE) && (state != ST_ERROR);
  assign bus.done        = (state == ST_DONE);
  assign bus.dense_start = (state == ST_DENSE_START);
  assign bus.relu_start  = (state == ST_RELU_START);
  assign bus.error       = error_q;
  assign bus.error_stage = error_stage_q;
  assign bus.layer_idx   = layer_q;

endmodule
